wt_dcache_ship_repl: RTL
========================

Name: wt_dcache_ship_repl

Overview:
- SHiP/RRIP replacement engine for the write-through L1 dcache.
- Keeps per-line metadata (valid, PC signature, reuse-outcome bit, 2-bit RRPV).
- Selects fill victims using an RRIP search/age state machine.
- Generates the hit-training, eviction-training and lookup traffic consumed by the signature hit counter table (SHCT) predictor; the predictor's 2-bit confidence sets insertion RRPV.

Parameters:
- NumSets, 256, cache sets; SetW = clog2(NumSets).
- NumWays, 8, associativity; WayW = clog2(NumWays).
- PcWidth, 64, PC width; must be >= 30.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous flush of all metadata
- hit_valid_i  in  1  cache hit this cycle
- hit_set_i  in  SetW  hit set
- hit_way_i  in  WayW  hit way
- inval_valid_i  in  1  line invalidation
- inval_set_i  in  SetW  invalidated set
- inval_way_i  in  WayW  invalidated way
- fill_req_i  in  1  victim request; held until fill_ack_o
- fill_set_i  in  SetW  fill set
- fill_pc_i  in  PcWidth  PC of missing access
- fill_ack_o  out  1  one-cycle victim-valid pulse
- fill_way_o  out  WayW  chosen way, valid with fill_ack_o
- pred_shct_o  out  14  signature of pending fill, to predictor lookup
- pred_result_i  in  2  predictor counter for pred_shct_o (combinational)
- pred_hit_o  out  1  train-up pulse
- pred_hit_shct_o  out  14  signature of hit line
- pred_miss_o  out  1  eviction pulse
- pred_miss_shct_o  out  14  evicted signature
- pred_outcome_o  out  1  evicted line's reuse bit

Behaviour:
- Signature: sig = fill_pc_i[15:2] XOR fill_pc_i[29:16].
- Line state reset/flush: valid=0, sig=0, outcome=0, rrpv=3.
- Output reset values: all outputs 0 and FSM=IDLE.
- Hit, hit_valid_i on a valid line:
  - Next cycle: rrpv=0, outcome=1.
  - Next cycle, registered: pred_hit_o=1 and pred_hit_shct_o=stored sig.
  - Hit on an invalid line: ignored, no pulse.
- Invalidate: next cycle valid=0, rrpv=3; no predictor training.
- FSM states: IDLE, SEARCH, AGE, INSERT.
  - IDLE: on fill_req_i, latch set and sig (pred_shct_o = latched sig, stable until return to IDLE); go to SEARCH.
  - SEARCH: if any invalid way, pick the lowest-index invalid way. Else pick the lowest-index way with rrpv==3. If a way is found, go to INSERT; else go to AGE.
  - AGE: rrpv+1 for every way in the set (none is 3, no overflow); go to SEARCH. At most 3 AGE visits per fill.
  - INSERT:
    - fill_ack_o=1, fill_way_o=victim.
    - Write sig, outcome=0, valid=1.
    - rrpv = 3 if pred_result_i==0, else 2.
    - If the victim was valid: next cycle pred_miss_o=1, pred_miss_shct_o=victim sig, pred_outcome_o=victim outcome.
    - Go to IDLE.
- Latency from accepting cycle T:
  - Invalid or rrpv==3 way present: ack at T+2.
  - Worst case (all rrpv==0): ack at T+8.
- fill_set_i and fill_pc_i are sampled only in IDLE.
- The next request can be accepted the cycle after ack.
- Simultaneous events:
  - Hit and FSM in the same set: SEARCH uses registered state; the hit update is visible next cycle.
  - Hit/inval to the INSERT way in the INSERT cycle: insert wins.
  - Hit to any way during AGE: hit's rrpv=0 wins over aging.
  - Inval and hit to the same line in the same cycle: inval wins, no pred_hit_o.
  - pred_hit_o and pred_miss_o may pulse in the same cycle.
- flush_i:
  - All lines reset next cycle; FSM to IDLE.
  - Pending fill abandoned, no ack, no training pulses; requester re-issues.
  - flush_i overrides hit/inval/insert.
- Reset mid-fill: same as flush, asynchronous.

Test Plan:
- Empty set 5, fill pc=0x0000_1234 -> ack at T+2, way 0; pred_shct_o=0x048D; no pred_miss_o.
- Fill set 5 eight times with pred_result_i=0, ninth fill pc=0x8000_0040 -> ways 0..7, then victim way 0 at T+2. Next cycle: pred_miss_o=1, pred_miss_shct_o=way-0 sig, pred_outcome_o=0.
- Full set, all rrpv=0 via hits -> exactly 3 AGE passes; ack at T+8, way 0. Eviction outcome=1 and pred_hit_o pulsed once per hit.
- Insert with pred_result_i=3 into way 2 and pred_result_i=0 into way 3, then fill -> way 3 (rrpv 3) selected, not way 2 (rrpv 2).
- Hit on the INSERT way during the INSERT cycle -> new line rrpv per prediction, outcome=0, no pred_hit_o. Same-cycle inval+hit -> line invalid, no pred_hit_o.
- flush_i asserted during AGE -> no fill_ack_o; next cycle all lines invalid. Re-issued fill picks way 0 at T+2.

Source files
------------

// File: rtl/wt_dcache_ship_repl.sv
// SHiP/RRIP replacement engine for the write-through L1 dcache: per-line
// metadata, RRIP victim search/aging and SHCT predictor training traffic.
module wt_dcache_ship_repl #(
    parameter int unsigned NumSets = 256,
    parameter int unsigned NumWays = 8,
    parameter int unsigned PcWidth = 64,
    localparam int unsigned SetW = $clog2(NumSets),
    localparam int unsigned WayW = $clog2(NumWays)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               hit_valid_i,
    input  logic [SetW-1:0]    hit_set_i,
    input  logic [WayW-1:0]    hit_way_i,
    input  logic               inval_valid_i,
    input  logic [SetW-1:0]    inval_set_i,
    input  logic [WayW-1:0]    inval_way_i,
    input  logic               fill_req_i,
    input  logic [SetW-1:0]    fill_set_i,
    input  logic [PcWidth-1:0] fill_pc_i,
    output logic               fill_ack_o,
    output logic [WayW-1:0]    fill_way_o,
    output logic [13:0]        pred_shct_o,
    input  logic [1:0]         pred_result_i,
    output logic               pred_hit_o,
    output logic [13:0]        pred_hit_shct_o,
    output logic               pred_miss_o,
    output logic [13:0]        pred_miss_shct_o,
    output logic               pred_outcome_o
);

    typedef enum logic [1:0] {IDLE, SEARCH, AGE, INSERT} state_t;

    state_t          state_reg;
    logic [SetW-1:0] set_reg;

    logic [NumWays-1:0]            valid_reg   [NumSets];
    logic [NumWays-1:0][13:0]      sig_reg     [NumSets];
    logic [NumWays-1:0]            outcome_reg [NumSets];
    logic [NumWays-1:0][1:0]       rrpv_reg    [NumSets];

    logic [13:0] fill_sig;
    assign fill_sig = fill_pc_i[15:2] ^ fill_pc_i[29:16];

    // Only PC bits [29:2] feed the signature.
    logic unused_pc_lo;
    assign unused_pc_lo = ^fill_pc_i[1:0];
    generate
        if (PcWidth > 30) begin : g_pc_hi
            logic unused_pc_hi;
            assign unused_pc_hi = ^fill_pc_i[PcWidth-1:30];
        end
    endgenerate

    logic [NumWays-1:0] free_vec;
    logic [NumWays-1:0] distant_vec;
    generate
        for (genvar gi = 0; gi < NumWays; gi++) begin : g_way
            assign free_vec[gi]    = ~valid_reg[set_reg][gi];
            assign distant_vec[gi] = (rrpv_reg[set_reg][gi] == 2'd3);
        end
    endgenerate

    logic            free_found;
    logic            distant_found;
    logic [WayW-1:0] free_way;
    logic [WayW-1:0] distant_way;

    // Descending scan so the lowest matching index is the one that sticks.
    always_comb begin
        free_found    = |free_vec;
        distant_found = |distant_vec;
        free_way      = '0;
        distant_way   = '0;
        for (int i = NumWays - 1; i >= 0; i--) begin
            if (free_vec[i])    free_way    = WayW'(i);
            if (distant_vec[i]) distant_way = WayW'(i);
        end
    end

    logic hit_take;
    logic inval_take;
    logic insert_now;
    logic aging;

    // A hit trains only a valid line that is neither invalidated nor replaced this cycle.
    assign hit_take   = hit_valid_i && valid_reg[hit_set_i][hit_way_i] && !flush_i
                        && !(inval_valid_i && inval_set_i == hit_set_i && inval_way_i == hit_way_i)
                        && !(state_reg == INSERT && set_reg == hit_set_i && fill_way_o == hit_way_i);
    assign inval_take = inval_valid_i && !flush_i;
    assign insert_now = (state_reg == INSERT) && !flush_i;
    assign aging      = (state_reg == AGE) && !flush_i;

    // Later assignments win: aging < hit < invalidate < insert.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < NumSets; s++) begin
                valid_reg[s]   <= '0;
                sig_reg[s]     <= '0;
                outcome_reg[s] <= '0;
                rrpv_reg[s]    <= {NumWays{2'd3}};
            end
        end else if (flush_i) begin
            for (int s = 0; s < NumSets; s++) begin
                valid_reg[s]   <= '0;
                sig_reg[s]     <= '0;
                outcome_reg[s] <= '0;
                rrpv_reg[s]    <= {NumWays{2'd3}};
            end
        end else begin
            if (aging) begin
                for (int w = 0; w < NumWays; w++) begin
                    if (rrpv_reg[set_reg][w] != 2'd3) begin
                        rrpv_reg[set_reg][w] <= rrpv_reg[set_reg][w] + 2'd1;
                    end
                end
            end
            if (hit_take) begin
                rrpv_reg[hit_set_i][hit_way_i]    <= 2'd0;
                outcome_reg[hit_set_i][hit_way_i] <= 1'b1;
            end
            if (inval_take) begin
                valid_reg[inval_set_i][inval_way_i] <= 1'b0;
                rrpv_reg[inval_set_i][inval_way_i]  <= 2'd3;
            end
            if (insert_now) begin
                valid_reg[set_reg][fill_way_o]   <= 1'b1;
                sig_reg[set_reg][fill_way_o]     <= pred_shct_o;
                outcome_reg[set_reg][fill_way_o] <= 1'b0;
                rrpv_reg[set_reg][fill_way_o]    <= (pred_result_i == 2'd0) ? 2'd3 : 2'd2;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg        <= IDLE;
            set_reg          <= '0;
            fill_ack_o       <= 1'b0;
            fill_way_o       <= '0;
            pred_shct_o      <= '0;
            pred_hit_o       <= 1'b0;
            pred_hit_shct_o  <= '0;
            pred_miss_o      <= 1'b0;
            pred_miss_shct_o <= '0;
            pred_outcome_o   <= 1'b0;
        end else begin
            fill_ack_o  <= 1'b0;
            pred_miss_o <= 1'b0;
            pred_hit_o  <= hit_take;
            if (hit_take) begin
                pred_hit_shct_o <= sig_reg[hit_set_i][hit_way_i];
            end
            if (flush_i) begin
                state_reg <= IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (fill_req_i) begin
                            set_reg     <= fill_set_i;
                            pred_shct_o <= fill_sig;
                            state_reg   <= SEARCH;
                        end
                    end
                    SEARCH: begin
                        if (free_found || distant_found) begin
                            fill_way_o <= free_found ? free_way : distant_way;
                            fill_ack_o <= 1'b1;
                            state_reg  <= INSERT;
                        end else begin
                            state_reg <= AGE;
                        end
                    end
                    AGE: state_reg <= SEARCH;
                    INSERT: begin
                        if (valid_reg[set_reg][fill_way_o]) begin
                            pred_miss_o      <= 1'b1;
                            pred_miss_shct_o <= sig_reg[set_reg][fill_way_o];
                            pred_outcome_o   <= outcome_reg[set_reg][fill_way_o];
                        end
                        state_reg <= IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule
